// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the FIFO controller: FSM states, round-robin encoding and strobe decode.
package fifo_pkg;

   localparam int DEPTH_DEF = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      WPTR  = 3'd2,
      READ  = 3'd3
   } state_e;

   typedef enum logic {
      PUSH = 1'b0,
      POP  = 1'b1
   } rr_e;

   typedef struct packed {
      logic ld1;
      logic ld2;
      logic ld3;
      logic push_ack;
      logic pop_ack;
      logic busy;
   } ctl_t;

   // Moore decode: every strobe is a pure function of the state it is registered against.
   function automatic ctl_t decode(state_e s);
      ctl_t c;
      c = '0;
      case (s)
         WRITE: begin c.ld1 = 1'b1; c.busy = 1'b1; end
         WPTR:  begin c.ld2 = 1'b1; c.push_ack = 1'b1; c.busy = 1'b1; end
         READ:  begin c.ld3 = 1'b1; c.pop_ack = 1'b1; c.busy = 1'b1; end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Requester/datapath side bundle of the FIFO controller. FIFO_ERR_FLAG_EN adds ovf_err/udf_err.
interface fifo_ctrl_if #(parameter int DEPTH = fifo_pkg::DEPTH_DEF);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic             push_req;
   logic             pop_req;
   logic             full;
   logic             empty;
   logic             ld1;
   logic             ld2;
   logic             ld3;
   logic             push_ack;
   logic             pop_ack;
   logic             busy;
   logic [LVL_W-1:0] level;

`ifdef FIFO_ERR_FLAG_EN
   logic             ovf_err;
   logic             udf_err;

   modport master (
      output push_req, pop_req, full, empty,
      input  ld1, ld2, ld3, push_ack, pop_ack, busy, level, ovf_err, udf_err
   );

   modport slave (
      input  push_req, pop_req, full, empty,
      output ld1, ld2, ld3, push_ack, pop_ack, busy, level, ovf_err, udf_err
   );
`else
   modport master (
      output push_req, pop_req, full, empty,
      input  ld1, ld2, ld3, push_ack, pop_ack, busy, level
   );

   modport slave (
      input  push_req, pop_req, full, empty,
      output ld1, ld2, ld3, push_ack, pop_ack, busy, level
   );
`endif

endinterface

// File: rtl/fifo_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; req[0]=push, req[1]=pop. Last grant resets to POP so push wins first.
module rr_arb2
   import fifo_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] gnt_o
);

   rr_e last_q;

   always_comb begin
      gnt_o    = 2'b00;
      gnt_o[0] = req_i[0] & (~req_i[1] | (last_q == POP));
      gnt_o[1] = req_i[1] & (~req_i[0] | (last_q == PUSH));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_q <= POP;
      else if (advance_i && (gnt_o != 2'b00))
         last_q <= gnt_o[1] ? POP : PUSH;
   end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller FSM: arbitrates push/pop, sequences ld1/ld2/ld3, acks and occupancy level.
// Optional sticky ovf_err/udf_err flags are built when FIFO_ERR_FLAG_EN is defined.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEF,
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic       clk,
   input  logic       rst,
   fifo_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   ctl_t             ctl_q;
   logic [LVL_W-1:0] level_q;
   logic             in_idle;
   logic [1:0]       req, gnt;

   // Requests only count while idle and only if the datapath can actually serve them.
   assign in_idle = (state_q == IDLE);
   assign req     = {in_idle & bus.pop_req & ~bus.empty,
                     in_idle & bus.push_req & ~bus.full};

   rr_arb2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req),
      .advance_i (in_idle),
      .gnt_o     (gnt)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = gnt[0] ? WRITE : (gnt[1] ? READ : IDLE);
         WRITE:   state_d = WPTR;
         WPTR:    state_d = IDLE;
         READ:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered against the next state so they line up with state_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ctl_q   <= '0;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         ctl_q   <= decode(state_d);
         if (state_d == WPTR && level_q != LVL_W'(DEPTH))
            level_q <= level_q + 1'b1;
         else if (state_d == READ && level_q != '0)
            level_q <= level_q - 1'b1;
      end
   end

   assign bus.ld1      = ctl_q.ld1;
   assign bus.ld2      = ctl_q.ld2;
   assign bus.ld3      = ctl_q.ld3;
   assign bus.push_ack = ctl_q.push_ack;
   assign bus.pop_ack  = ctl_q.pop_ack;
   assign bus.busy     = ctl_q.busy;
   assign bus.level    = level_q;

`ifdef FIFO_ERR_FLAG_EN
   logic ovf_q, udf_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (in_idle && bus.push_req && bus.full)  ovf_q <= 1'b1;
         if (in_idle && bus.pop_req  && bus.empty) udf_q <= 1'b1;
      end
   end

   assign bus.ovf_err = ovf_q;
   assign bus.udf_err = udf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: handshake timing, arbitration, hold-off, reset abort, level saturation.
module tb_fifo_ctrl;

   localparam int DEPTH = 16;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   fifo_ctrl_if #(.DEPTH(DEPTH)) bus ();

   fifo_ctrl #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_push(input string tag, input int lvl_exp);
      bus.push_req = 1'b1;
      tick();
      chk({tag, "_ld1"}, int'(bus.ld1), 1);
      tick();
      chk({tag, "_ack"}, int'(bus.push_ack & bus.ld2), 1);
      bus.push_req = 1'b0;
      tick();
      chk({tag, "_lvl"}, int'(bus.level), lvl_exp);
   endtask

   task automatic do_pop(input string tag, input int lvl_exp);
      bus.pop_req = 1'b1;
      tick();
      chk({tag, "_ack"}, int'(bus.pop_ack & bus.ld3), 1);
      bus.pop_req = 1'b0;
      tick();
      chk({tag, "_lvl"}, int'(bus.level), lvl_exp);
   endtask

   initial begin
      int n_ld, n_ack, n_busy, n_both;
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      bus.push_req = 1'b0;
      bus.pop_req  = 1'b0;
      bus.full     = 1'b0;
      bus.empty    = 1'b0;
      repeat (2) tick();
      chk("rst_ctl",   int'({bus.ld1, bus.ld2, bus.ld3, bus.push_ack, bus.pop_ack, bus.busy}), 0);
      chk("rst_level", int'(bus.level), 0);
`ifdef FIFO_ERR_FLAG_EN
      chk("rst_err", int'({bus.ovf_err, bus.udf_err}), 0);
`endif
      rst = 1'b1;
      tick();

      // single push: ld1 next cycle, ld2+ack the one after, then idle
      bus.push_req = 1'b1;
      tick();
      chk("p1_ld1",  int'(bus.ld1), 1);
      chk("p1_ack0", int'(bus.push_ack), 0);
      chk("p1_busy", int'(bus.busy), 1);
      tick();
      chk("p1_ld2",  int'(bus.ld2), 1);
      chk("p1_ack",  int'(bus.push_ack), 1);
      chk("p1_ld1b", int'(bus.ld1), 0);
      bus.push_req = 1'b0;
      tick();
      chk("p1_idle", int'(bus.busy), 0);
      chk("p1_lvl",  int'(bus.level), 1);

      do_push("p2", 2);
      do_push("p3", 3);
      do_push("p4", 4);
      do_pop("r1", 3);

      // both held: push (priority after a pop), pop, push
      bus.push_req = 1'b1;
      bus.pop_req  = 1'b1;
      tick();
      chk("rr1_ld1", int'(bus.ld1), 1);
      tick();
      chk("rr1_acks", int'({bus.push_ack, bus.pop_ack}), 2);
      tick();
      chk("rr_idle1", int'(bus.busy), 0);
      tick();
      chk("rr2_acks", int'({bus.push_ack, bus.pop_ack}), 1);
      tick();
      chk("rr_idle2", int'(bus.busy), 0);
      tick();
      chk("rr3_ld1", int'(bus.ld1), 1);
      tick();
      chk("rr3_acks", int'({bus.push_ack, bus.pop_ack}), 2);
      bus.push_req = 1'b0;
      bus.pop_req  = 1'b0;
      tick();
      chk("rr_lvl", int'(bus.level), 4);

      // push while full is held off, FSM never leaves IDLE
      bus.full     = 1'b1;
      bus.push_req = 1'b1;
      n_ld = 0; n_ack = 0; n_busy = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_ld   += int'(bus.ld1) + int'(bus.ld2);
         n_ack  += int'(bus.push_ack);
         n_busy += int'(bus.busy);
      end
      chk("full_ld",   n_ld, 0);
      chk("full_ack",  n_ack, 0);
      chk("full_busy", n_busy, 0);
`ifdef FIFO_ERR_FLAG_EN
      chk("ovf_err", int'(bus.ovf_err), 1);
      chk("udf_err0", int'(bus.udf_err), 0);
`endif
      bus.push_req = 1'b0;
      bus.full     = 1'b0;

      // full with both requests: only the pop side is eligible
      bus.full     = 1'b1;
      bus.push_req = 1'b1;
      bus.pop_req  = 1'b1;
      tick();
      chk("mix_rd", int'({bus.ld1, bus.ld3}), 1);
      bus.pop_req  = 1'b0;
      tick();
      chk("mix_lvl", int'(bus.level), 3);
      bus.push_req = 1'b0;
      bus.full     = 1'b0;
      tick();

      // reset during WRITE: nothing follows, outputs drop at once
      bus.push_req = 1'b1;
      tick();
      chk("ab_ld1", int'(bus.ld1), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("ab_now",  int'({bus.ld1, bus.busy}), 0);
      chk("ab_lvl",  int'(bus.level), 0);
      bus.push_req = 1'b0;
      tick();
      chk("ab_next", int'({bus.ld2, bus.push_ack}), 0);
      rst = 1'b1;
      tick();

      // pop at level 0 with empty low: acked, level does not wrap
      do_pop("r0", 0);

      // pop while empty is held off
      bus.empty   = 1'b1;
      bus.pop_req = 1'b1;
      n_ack = 0; n_busy = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_ack  += int'(bus.pop_ack) + int'(bus.ld3);
         n_busy += int'(bus.busy);
      end
      chk("emp_ack",  n_ack, 0);
      chk("emp_busy", n_busy, 0);
`ifdef FIFO_ERR_FLAG_EN
      chk("udf_err", int'(bus.udf_err), 1);
`endif
      bus.pop_req = 1'b0;
      bus.empty   = 1'b0;
      tick();

      // fill to DEPTH
      n_both = 0;
      for (int i = 1; i <= DEPTH; i++) do_push("fill", i);
      chk("fill_lvl", int'(bus.level), 16);

      // 17th push with full asserted stalls
      bus.full     = 1'b1;
      bus.push_req = 1'b1;
      n_ld = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_ld += int'(bus.ld1) + int'(bus.push_ack);
      end
      chk("p17_stall", n_ld, 0);
      chk("p17_lvl",   int'(bus.level), 16);
      bus.push_req = 1'b0;
      bus.full     = 1'b0;
      tick();

      // push beyond DEPTH with full low: still acked, level saturates
      do_push("sat", 16);

      // drain two and watch acks never overlap
      bus.pop_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_both += int'(bus.push_ack & bus.pop_ack);
      end
      bus.pop_req = 1'b0;
      tick();
      chk("drain_lvl",  int'(bus.level), 14);
      chk("ack_overlap", n_both, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
